mod_mem_store_beat_gen: RTL and testbench

Parametrised store path between execute stage and data-memory bus. Takes one store request (funct3, byte address, register value) over a valid/ready handshake and converts it into one or two aligned, byte-strobed bus beats with registered outputs. Generalises the combinational store aligner in three ways: XLEN=32/64, doubleword stores, and optional splitting of misaligned stores across two bus words. Sits after address generation and before the data-memory port.

---
 rtl/mod_mem_store_beat_gen.sv | 196 +++++++++++++++++++
 tb/tb_mod_mem_store_beat_gen.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_mem_store_beat_gen.sv
// Store beat generator: turns one store request (funct3, byte address, data) into one or two
// aligned, byte-strobed bus beats with registered outputs.
// Optional feature macro: MEM_STORE_SPLIT_EN -- when defined, stores crossing an XLEN-word
// boundary are issued as two beats; when undefined they are rejected with err_o.
module mod_mem_store_beat_gen #(
  parameter int unsigned XLEN = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [2:0]          req_funct3_i,
  input  logic [XLEN-1:0]     req_addr_i,
  input  logic [XLEN-1:0]     req_data_i,
  output logic                mem_valid_o,
  input  logic                mem_ready_i,
  output logic [XLEN-1:0]     mem_addr_o,
  output logic [XLEN-1:0]     mem_wdata_o,
  output logic [XLEN/8-1:0]   mem_wstrb_o,
  output logic                done_o,
  output logic                err_o
);

  localparam int unsigned BYTES = XLEN / 8;
  localparam int unsigned OFFW  = $clog2(BYTES);
  localparam logic [2*BYTES-1:0] MaskOne = {{(2*BYTES-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StBeat0, StBeat1, StResp} state_e;

  state_e               state_q, state_d;
  logic                 mem_valid_q, mem_valid_d;
  logic [XLEN-1:0]      mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]      mem_wdata_q, mem_wdata_d;
  logic [BYTES-1:0]     mem_wstrb_q, mem_wstrb_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  // Request decode
  int unsigned          size;
  logic [OFFW-1:0]      offset;
  logic [2*BYTES-1:0]   mask;
  logic [XLEN-1:0]      data_sized;
  logic [2*XLEN-1:0]    data2;
  logic [XLEN-1:0]      base;
  logic                 illegal;
  logic                 split;
  logic                 reject;

`ifdef MEM_STORE_SPLIT_EN
  // Second-beat payload captured at accept time so BEAT1 is a plain register load
  logic [XLEN-1:0]      hi_addr_q, hi_addr_d;
  logic [XLEN-1:0]      hi_wdata_q, hi_wdata_d;
  logic [BYTES-1:0]     hi_wstrb_q, hi_wstrb_d;
  logic                 split_q, split_d;
`else
  logic                 unused_hi;
  assign unused_hi = ^data2[2*XLEN-1:XLEN];
`endif

  // Decode size, lane placement and legality of the incoming request
  always_comb begin
    size   = 32'd1 << req_funct3_i[1:0];
    offset = req_addr_i[OFFW-1:0];
    mask   = ((MaskOne << size) - MaskOne) << offset;
    for (int unsigned i = 0; i < BYTES; i++) begin
      data_sized[8*i +: 8] = (i < size) ? req_data_i[8*i +: 8] : 8'h00;
    end
    data2   = {{XLEN{1'b0}}, data_sized} << {offset, 3'b000};
    base    = {req_addr_i[XLEN-1:OFFW], {OFFW{1'b0}}};
    illegal = req_funct3_i[2] || ((req_funct3_i[1:0] == 2'b11) && (XLEN == 32));
    split   = |mask[2*BYTES-1:BYTES];
`ifdef MEM_STORE_SPLIT_EN
    reject  = illegal;
`else
    reject  = illegal || split;
`endif
  end

  // Next-state and next-output logic; outputs only change through registers
  always_comb begin
    state_d     = state_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
`ifdef MEM_STORE_SPLIT_EN
    hi_addr_d   = hi_addr_q;
    hi_wdata_d  = hi_wdata_q;
    hi_wstrb_d  = hi_wstrb_q;
    split_d     = split_q;
`endif
    unique case (state_q)
      StIdle, StResp: begin
        if (req_valid_i) begin
          if (reject) begin
            state_d = StResp;
            err_d   = 1'b1;
          end else begin
            state_d     = StBeat0;
            mem_valid_d = 1'b1;
            mem_addr_d  = base;
            mem_wdata_d = data2[XLEN-1:0];
            mem_wstrb_d = mask[BYTES-1:0];
`ifdef MEM_STORE_SPLIT_EN
            hi_addr_d   = base + XLEN'(BYTES);
            hi_wdata_d  = data2[2*XLEN-1:XLEN];
            hi_wstrb_d  = mask[2*BYTES-1:BYTES];
            split_d     = split;
`endif
          end
        end else begin
          state_d = StIdle;
        end
      end
      StBeat0: begin
        if (mem_ready_i) begin
`ifdef MEM_STORE_SPLIT_EN
          if (split_q) begin
            state_d     = StBeat1;
            mem_addr_d  = hi_addr_q;
            mem_wdata_d = hi_wdata_q;
            mem_wstrb_d = hi_wstrb_q;
          end else
`endif
          begin
            state_d     = StResp;
            mem_valid_d = 1'b0;
            done_d      = 1'b1;
          end
        end
      end
`ifdef MEM_STORE_SPLIT_EN
      StBeat1: begin
        if (mem_ready_i) begin
          state_d     = StResp;
          mem_valid_d = 1'b0;
          done_d      = 1'b1;
        end
      end
`endif
      default: begin
        state_d     = StIdle;
        mem_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any beat in flight
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

`ifdef MEM_STORE_SPLIT_EN
  // Second-beat payload registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hi_addr_q  <= '0;
      hi_wdata_q <= '0;
      hi_wstrb_q <= '0;
      split_q    <= 1'b0;
    end else begin
      hi_addr_q  <= hi_addr_d;
      hi_wdata_q <= hi_wdata_d;
      hi_wstrb_q <= hi_wstrb_d;
      split_q    <= split_d;
    end
  end
`endif

  assign req_ready_o = (state_q == StIdle) || (state_q == StResp);
  assign mem_valid_o = mem_valid_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_wstrb_o = mem_wstrb_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_mod_mem_store_beat_gen.sv
// Self-checking bench for mod_mem_store_beat_gen: XLEN=32 and XLEN=64 instances, a byte-level
// reference model feeding per-instance scoreboards, plus directed latency/stall/reset checks.
// Honours MEM_STORE_SPLIT_EN in the reference model.
module tb_mod_mem_store_beat_gen;

`ifdef MEM_STORE_SPLIT_EN
  localparam bit SplitEn = 1'b1;
`else
  localparam bit SplitEn = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        v32, r32o, mv32, mr32, done32, err32;
  logic [2:0]  f32;
  logic [31:0] a32, d32, ma32, mw32;
  logic [3:0]  ms32;

  logic        v64, r64o, mv64, mr64, done64, err64;
  logic [2:0]  f64;
  logic [63:0] a64, d64, ma64, mw64;
  logic [7:0]  ms64;

  mod_mem_store_beat_gen #(.XLEN(32)) dut32 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(v32), .req_ready_o(r32o),
    .req_funct3_i(f32), .req_addr_i(a32), .req_data_i(d32), .mem_valid_o(mv32),
    .mem_ready_i(mr32), .mem_addr_o(ma32), .mem_wdata_o(mw32), .mem_wstrb_o(ms32),
    .done_o(done32), .err_o(err32)
  );

  mod_mem_store_beat_gen #(.XLEN(64)) dut64 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(v64), .req_ready_o(r64o),
    .req_funct3_i(f64), .req_addr_i(a64), .req_data_i(d64), .mem_valid_o(mv64),
    .mem_ready_i(mr64), .mem_addr_o(ma64), .mem_wdata_o(mw64), .mem_wstrb_o(ms64),
    .done_o(done64), .err_o(err64)
  );

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  strb;
  } beat_t;

  beat_t bq32[$], bq64[$];
  bit    rq32[$], rq64[$];
  beat_t e32, e64;
  bit    re32, re64;
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Byte-by-byte reference: place each stored byte into word 0 or word 1 of the pair
  task automatic model(input int nb, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] data, output bit err, output int nbeats,
                       output beat_t b0, output beat_t b1);
    int size, off, pos, lane;
    bit sp;
    logic [63:0] base, wmask;
    wmask = (nb == 4) ? 64'hFFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    size  = 1 << f3[1:0];
    off   = int'(addr % 64'(nb));
    base  = addr - 64'(off);
    b0 = '0;
    b1 = '0;
    sp = 1'b0;
    for (int k = 0; k < size; k++) begin
      pos  = off + k;
      lane = pos % nb;
      if (pos >= nb) begin
        sp = 1'b1;
        b1.wdata[8*lane +: 8] = data[8*k +: 8];
        b1.strb[lane] = 1'b1;
      end else begin
        b0.wdata[8*lane +: 8] = data[8*k +: 8];
        b0.strb[lane] = 1'b1;
      end
    end
    b0.addr = base;
    b1.addr = (base + 64'(nb)) & wmask;
    err    = f3[2] || (f3[1:0] == 2'b11 && nb == 4) || (sp && !SplitEn);
    nbeats = err ? 0 : (sp ? 2 : 1);
  endtask

  task automatic push(input int nb, input logic [2:0] f3, input logic [63:0] addr,
                      input logic [63:0] data);
    bit err;
    int n;
    beat_t b0, b1;
    model(nb, f3, addr, data, err, n, b0, b1);
    if (nb == 4) begin
      if (n >= 1) bq32.push_back(b0);
      if (n == 2) bq32.push_back(b1);
      rq32.push_back(err);
    end else begin
      if (n >= 1) bq64.push_back(b0);
      if (n == 2) bq64.push_back(b1);
      rq64.push_back(err);
    end
  endtask

  // Scoreboard monitor: compare every completed beat and every response pulse
  always @(negedge clk) begin
    if (rst_n) begin
      if (mv32 && mr32) begin
        if (bq32.size() == 0) begin
          checks++; errors++;
          $error("FAIL beat32_unexpected: observed addr 0x%0h expected no beat", ma32);
        end else begin
          e32 = bq32.pop_front();
          chk("beat32_addr", 64'(ma32), e32.addr);
          chk("beat32_wdata", 64'(mw32), e32.wdata);
          chk("beat32_wstrb", 64'(ms32), 64'(e32.strb));
        end
      end
      if (done32 || err32) begin
        if (rq32.size() == 0) begin
          checks++; errors++;
          $error("FAIL resp32_unexpected: observed done=%0b err=%0b expected none", done32, err32);
        end else begin
          re32 = rq32.pop_front();
          chk("resp32_err", 64'(err32), 64'(re32));
          chk("resp32_done", 64'(done32), 64'(!re32));
        end
      end
      if (mv64 && mr64) begin
        if (bq64.size() == 0) begin
          checks++; errors++;
          $error("FAIL beat64_unexpected: observed addr 0x%0h expected no beat", ma64);
        end else begin
          e64 = bq64.pop_front();
          chk("beat64_addr", ma64, e64.addr);
          chk("beat64_wdata", mw64, e64.wdata);
          chk("beat64_wstrb", 64'(ms64), 64'(e64.strb));
        end
      end
      if (done64 || err64) begin
        if (rq64.size() == 0) begin
          checks++; errors++;
          $error("FAIL resp64_unexpected: observed done=%0b err=%0b expected none", done64, err64);
        end else begin
          re64 = rq64.pop_front();
          chk("resp64_err", 64'(err64), 64'(re64));
          chk("resp64_done", 64'(done64), 64'(!re64));
        end
      end
    end
  end

  // Called at a negedge; returns just after the accepting posedge
  task automatic store32(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data,
                         output int acc);
    int n = 0;
    f32 = f3; a32 = addr; d32 = data; v32 = 1'b1;
    while (!r32o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept32_ready", 64'(r32o), 64'd1);
    push(4, f3, 64'(addr), 64'(data));
    acc = cyc;
    @(posedge clk);
    #1 v32 = 1'b0;
  endtask

  task automatic store64(input logic [2:0] f3, input logic [63:0] addr, input logic [63:0] data);
    int n = 0;
    f64 = f3; a64 = addr; d64 = data; v64 = 1'b1;
    while (!r64o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept64_ready", 64'(r64o), 64'd1);
    push(8, f3, addr, data);
    @(posedge clk);
    #1 v64 = 1'b0;
  endtask

  // Negedges from the call until a response pulse (bounded)
  task automatic wait_resp32(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(done32 || err32) && lat < 30);
  endtask

  task automatic wait_resp64(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(done64 || err64) && lat < 30);
  endtask

  initial begin
    int lat, acc_a, acc_b;
    rst_n = 1'b0;
    v32 = 1'b0; f32 = '0; a32 = '0; d32 = '0; mr32 = 1'b1;
    v64 = 1'b0; f64 = '0; a64 = '0; d64 = '0; mr64 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready32", 64'(r32o), 64'd1);
    chk("rst_valid32", 64'(mv32), 64'd0);
    chk("rst_done32", 64'(done32), 64'd0);
    chk("rst_err32", 64'(err32), 64'd0);
    chk("rst_addr32", 64'(ma32), 64'd0);
    chk("rst_wdata32", 64'(mw32), 64'd0);
    chk("rst_wstrb32", 64'(ms32), 64'd0);
    chk("rst_ready64", 64'(r64o), 64'd1);
    chk("rst_valid64", 64'(mv64), 64'd0);

    // SB at byte 3
    store32(3'b000, 32'h0000_1003, 32'hAABB_CCDD, acc_a);
    wait_resp32(lat);
    chk("sb_latency", 64'(lat), 64'd2);

    // SW with the bus stalled for three cycles
    @(posedge clk);
    #1 mr32 = 1'b0;
    @(negedge clk);
    store32(3'b010, 32'h0000_2000, 32'h1234_5678, acc_a);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_valid", 64'(mv32), 64'd1);
      chk("stall_addr", 64'(ma32), 64'h2000);
      chk("stall_wdata", 64'(mw32), 64'h1234_5678);
      chk("stall_wstrb", 64'(ms32), 64'hF);
      if (i == 2) begin
        @(posedge clk);
        #1 mr32 = 1'b1;
      end
    end
    wait_resp32(lat);
    chk("stall_done_lat", 64'(lat), 64'd1);

    // SW crossing a word boundary
    store32(3'b010, 32'h0000_2002, 32'h1234_5678, acc_a);
    wait_resp32(lat);
    chk("sw_split_lat", 64'(lat), SplitEn ? 64'd3 : 64'd1);

    // SH crossing the top of the address space
    store32(3'b001, 32'hFFFF_FFFF, 32'h1234_BEEF, acc_a);
    wait_resp32(lat);
    chk("sh_wrap_lat", 64'(lat), SplitEn ? 64'd3 : 64'd1);

    // Illegal funct3 values on XLEN=32
    store32(3'b011, 32'h0000_0010, 32'h0, acc_a);
    wait_resp32(lat);
    chk("sd32_err_lat", 64'(lat), 64'd1);
    store32(3'b100, 32'h0000_0010, 32'h0, acc_a);
    wait_resp32(lat);
    chk("f100_err_lat", 64'(lat), 64'd1);

    // Back-to-back: second request accepted in the RESP cycle of the first
    store32(3'b010, 32'h0000_3000, 32'hCAFE_F00D, acc_a);
    store32(3'b001, 32'h0000_3006, 32'h0000_BEEF, acc_b);
    chk("b2b_accept_gap", 64'(acc_b - acc_a), 64'd2);
    wait_resp32(lat);
    chk("b2b_done_lat", 64'(lat), 64'd2);

    // Misaligned SH inside one word
    store32(3'b001, 32'h0000_4001, 32'h0000_A55A, acc_a);
    wait_resp32(lat);
    chk("sh_inword_lat", 64'(lat), 64'd2);

    // XLEN=64
    @(negedge clk);
    store64(3'b011, 64'h8, 64'h0123_4567_89AB_CDEF);
    wait_resp64(lat);
    chk("sd64_lat", 64'(lat), 64'd2);
    store64(3'b100, 64'h0, 64'h1);
    wait_resp64(lat);
    chk("f100_64_lat", 64'(lat), 64'd1);
    store64(3'b010, 64'hC, 64'h1122_3344);
    wait_resp64(lat);
    chk("sw64_hi_lat", 64'(lat), 64'd2);
    store64(3'b001, 64'h7, 64'hBEEF);
    wait_resp64(lat);
    chk("sh64_split_lat", 64'(lat), SplitEn ? 64'd3 : 64'd1);

    // Reset while a beat waits on the bus
    @(posedge clk);
    #1 mr32 = 1'b0;
    @(negedge clk);
    store32(3'b010, 32'h0000_5000, 32'h0BAD_F00D, acc_a);
    @(negedge clk);
    chk("pre_rst_valid", 64'(mv32), 64'd1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    bq32.delete(); rq32.delete(); bq64.delete(); rq64.delete();
    mr32 = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 64'(mv32), 64'd0);
    chk("post_rst_ready", 64'(r32o), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_no_done", 64'(done32), 64'd0);
    end
    store32(3'b000, 32'h0000_6001, 32'h0000_005A, acc_a);
    wait_resp32(lat);
    chk("post_rst_sb_lat", 64'(lat), 64'd2);

    repeat (3) @(negedge clk);
    chk("sb32_drained", 64'(bq32.size() + rq32.size()), 64'd0);
    chk("sb64_drained", 64'(bq64.size() + rq64.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
